// File: rtl/gpu_math_pkg.sv
// gpu_math_pkg
//   Fixed-point types and helpers shared by the vertex pipeline.
//   - FIXEDPOINT_WIDTH / FIXEDPOINT_FRAC : default Q16.16 word format
//   - FIXEDPOINT_MAX                     : largest positive Q16.16 word
//   - Vector4_t                          : packed {x, y, z, w}, x in the MSBs
//   - vpd_state_e                        : perspective-divide control states
//   - fixed_point_multiply               : (a*b) >>> frac at double width
package gpu_math_pkg;

    localparam int FIXEDPOINT_WIDTH     = 32;
    localparam int FIXEDPOINT_FRAC      = 16;
    localparam int FIXEDPOINT_MUL_WIDTH = 2 * FIXEDPOINT_WIDTH;

    localparam logic [FIXEDPOINT_WIDTH-1:0] FIXEDPOINT_MAX = 32'h7FFF_FFFF;

    typedef struct packed {
        logic [FIXEDPOINT_WIDTH-1:0] x;
        logic [FIXEDPOINT_WIDTH-1:0] y;
        logic [FIXEDPOINT_WIDTH-1:0] z;
        logic [FIXEDPOINT_WIDTH-1:0] w;
    } Vector4_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIVIDE = 2'd1,
        ST_SCALE  = 2'd2,
        ST_OUTPUT = 2'd3
    } vpd_state_e;

    // Operands arrive already sign-extended to the double width; the caller
    // keeps whichever low bits it needs, so overflow simply wraps.
    function automatic logic [FIXEDPOINT_MUL_WIDTH-1:0] fixed_point_multiply(
        input logic signed [FIXEDPOINT_MUL_WIDTH-1:0] a,
        input logic signed [FIXEDPOINT_MUL_WIDTH-1:0] b,
        input int                                     frac
    );
        logic signed [FIXEDPOINT_MUL_WIDTH-1:0] product;
        product = a * b;
        return product >>> frac;
    endfunction

endpackage

// File: rtl/fixed_point_reciprocal.sv
// fixed_point_reciprocal
//   Restoring divider computing 2^(2*FRAC) / divisor, one quotient bit per
//   clock, WIDTH+1 clocks per division.
//   Ports:
//     i_clk, i_reset_n : clock, synchronous active-low reset
//     i_start          : load i_divisor and begin (ignored while busy)
//     i_divisor        : unsigned divisor, must be non-zero
//     o_busy           : a division is iterating
//     o_done           : the final quotient bit resolves on this clock edge;
//                        o_quotient / o_sat are valid from the next cycle
//     o_quotient       : quotient clamped to 2^(WIDTH-1)-1
//     o_sat            : raw quotient exceeded 2^(WIDTH-1)-1
module fixed_point_reciprocal #(
    parameter int WIDTH = 32,
    parameter int FRAC  = 16
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_divisor,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_quotient,
    output logic             o_sat
);

    localparam int CW = $clog2(WIDTH + 2);
    localparam int IW = $clog2(WIDTH + 1);

    // Dividend is the constant 1.0 * 1.0 in the doubled fraction format.
    localparam logic [WIDTH:0] DIVIDEND = {{WIDTH{1'b0}}, 1'b1} << (2 * FRAC);
    localparam logic [WIDTH-1:0] QUOT_MAX = {1'b0, {(WIDTH-1){1'b1}}};

    logic             busy_q, busy_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH:0]   quo_q, quo_d;
    logic [WIDTH-1:0] divisor_q, divisor_d;

    logic [IW-1:0]    bit_idx;
    logic [WIDTH:0]   trial;
    logic             trial_ge;

    always_comb begin
        busy_d    = busy_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        divisor_d = divisor_q;

        // Bring down the next dividend bit, MSB first.
        bit_idx  = IW'(cnt_q - CW'(1));
        trial    = {rem_q, DIVIDEND[bit_idx]};
        trial_ge = (trial >= {1'b0, divisor_q});

        if (busy_q) begin
            quo_d = {quo_q[WIDTH-1:0], trial_ge};
            // Remainder stays below the divisor, so WIDTH bits suffice.
            rem_d = trial_ge ? WIDTH'(trial - {1'b0, divisor_q})
                             : trial[WIDTH-1:0];
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                busy_d = 1'b0;
            end
        end else if (i_start) begin
            busy_d    = 1'b1;
            cnt_d     = CW'(WIDTH + 1);
            rem_d     = '0;
            quo_d     = '0;
            divisor_d = i_divisor;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            busy_q    <= 1'b0;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            divisor_q <= '0;
        end else begin
            busy_q    <= busy_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            divisor_q <= divisor_d;
        end
    end

    assign o_busy     = busy_q;
    assign o_done     = busy_q && (cnt_q == CW'(1));
    assign o_sat      = quo_q[WIDTH] | quo_q[WIDTH-1];
    assign o_quotient = o_sat ? QUOT_MAX : quo_q[WIDTH-1:0];

endmodule

// File: rtl/vertex_perspective_divide.sv
// vertex_perspective_divide
//   Converts a clip-space {x, y, z, w} vertex to {x/w, y/w, z/w, 1/w} in
//   signed fixed point (WIDTH bits, FRAC fractional bits). One vertex in
//   flight; 1/w comes from an iterative divider, then three multiplies.
//   Ports:
//     i_clk, i_reset_n : clock, synchronous active-low reset
//     i_valid/o_ready  : input handshake, i_vector = {x, y, z, w}
//     o_valid/i_ready  : output handshake, o_vector = {x', y', z', 1/w}
//     o_div_by_zero    : w was exactly zero (qualified by o_valid)
//     o_recip_sat      : |1/w| clamped to the largest positive word
module vertex_perspective_divide
    import gpu_math_pkg::*;
#(
    parameter int WIDTH = FIXEDPOINT_WIDTH,
    parameter int FRAC  = FIXEDPOINT_FRAC
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [4*WIDTH-1:0] i_vector,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [4*WIDTH-1:0] o_vector,
    output logic               o_div_by_zero,
    output logic               o_recip_sat
);

    localparam int MUL_W = FIXEDPOINT_MUL_WIDTH;
    localparam logic [WIDTH-1:0] RECIP_MAX = {1'b0, {(WIDTH-1){1'b1}}};

    vpd_state_e state_q, state_d;

    // Index 0..2 = x, y, z
    logic [WIDTH-1:0]   comp_q [3];
    logic [WIDTH-1:0]   comp_d [3];
    logic [WIDTH-1:0]   in_comp [3];
    logic [WIDTH-1:0]   scaled [3];

    logic               w_neg_q, w_neg_d;
    logic [4*WIDTH-1:0] vector_q, vector_d;
    logic               div_by_zero_q, div_by_zero_d;
    logic               recip_sat_q, recip_sat_d;

    logic [WIDTH-1:0]   in_w;
    logic               in_w_zero;
    logic               in_w_neg;
    logic [WIDTH-1:0]   in_w_abs;
    logic               accept;

    logic               div_start;
    logic               div_busy;
    logic               div_done;
    logic [WIDTH-1:0]   div_quotient;
    logic               div_sat;
    logic [WIDTH-1:0]   recip;

    assign in_w      = i_vector[WIDTH-1:0];
    assign in_w_zero = (in_w == '0);
    assign in_w_neg  = in_w[WIDTH-1];
    // The most negative w maps to 2^(WIDTH-1), which is still representable
    // as an unsigned divisor.
    assign in_w_abs  = in_w_neg ? (~in_w + WIDTH'(1)) : in_w;

    assign o_ready   = (state_q == ST_IDLE) && !div_busy;
    assign accept    = i_valid && o_ready;
    assign div_start = accept && !in_w_zero;

    assign recip     = w_neg_q ? (~div_quotient + WIDTH'(1)) : div_quotient;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_comp
            assign in_comp[gi] = i_vector[(4-gi)*WIDTH-1 -: WIDTH];
            assign scaled[gi]  = WIDTH'(fixed_point_multiply(
                                     MUL_W'(signed'(comp_q[gi])),
                                     MUL_W'(signed'(recip)),
                                     FRAC));
        end
    endgenerate

    fixed_point_reciprocal #(
        .WIDTH (WIDTH),
        .FRAC  (FRAC)
    ) u_recip (
        .i_clk      (i_clk),
        .i_reset_n  (i_reset_n),
        .i_start    (div_start),
        .i_divisor  (in_w_abs),
        .o_busy     (div_busy),
        .o_done     (div_done),
        .o_quotient (div_quotient),
        .o_sat      (div_sat)
    );

    always_comb begin
        state_d       = state_q;
        w_neg_d       = w_neg_q;
        vector_d      = vector_q;
        div_by_zero_d = div_by_zero_q;
        recip_sat_d   = recip_sat_q;
        for (int i = 0; i < 3; i++) begin
            comp_d[i] = comp_q[i];
        end

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    for (int i = 0; i < 3; i++) begin
                        comp_d[i] = in_comp[i];
                    end
                    w_neg_d       = in_w_neg;
                    div_by_zero_d = in_w_zero;
                    recip_sat_d   = 1'b0;
                    if (in_w_zero) begin
                        // Skip the divider entirely; answer is a fixed vector.
                        vector_d = {{(3*WIDTH){1'b0}}, RECIP_MAX};
                        state_d  = ST_OUTPUT;
                    end else begin
                        state_d  = ST_DIVIDE;
                    end
                end
            end
            ST_DIVIDE: begin
                if (div_done) begin
                    state_d = ST_SCALE;
                end
            end
            ST_SCALE: begin
                vector_d    = {scaled[0], scaled[1], scaled[2], recip};
                recip_sat_d = div_sat;
                state_d     = ST_OUTPUT;
            end
            ST_OUTPUT: begin
                if (i_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q       <= ST_IDLE;
            w_neg_q       <= 1'b0;
            vector_q      <= '0;
            div_by_zero_q <= 1'b0;
            recip_sat_q   <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                comp_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            w_neg_q       <= w_neg_d;
            vector_q      <= vector_d;
            div_by_zero_q <= div_by_zero_d;
            recip_sat_q   <= recip_sat_d;
            for (int i = 0; i < 3; i++) begin
                comp_q[i] <= comp_d[i];
            end
        end
    end

    assign o_valid       = (state_q == ST_OUTPUT);
    assign o_vector      = vector_q;
    assign o_div_by_zero = div_by_zero_q;
    assign o_recip_sat   = recip_sat_q;

endmodule

// File: tb/tb_vertex_perspective_divide.sv
// tb_vertex_perspective_divide
//   Directed vectors with hand-computed Q16.16 results for the perspective
//   divide stage: normal, negative w, w==0, saturating 1/w, wrap-around,
//   backpressure and mid-divide reset.
module tb_vertex_perspective_divide;

    logic         i_clk = 1'b0;
    logic         i_reset_n;
    logic         i_valid;
    logic         o_ready;
    logic [127:0] i_vector;
    logic         o_valid;
    logic         i_ready;
    logic [127:0] o_vector;
    logic         o_div_by_zero;
    logic         o_recip_sat;

    int n_compared   = 0;
    int n_mismatched = 0;

    always #5 i_clk = ~i_clk;

    vertex_perspective_divide dut (
        .i_clk         (i_clk),
        .i_reset_n     (i_reset_n),
        .i_valid       (i_valid),
        .o_ready       (o_ready),
        .i_vector      (i_vector),
        .o_valid       (o_valid),
        .i_ready       (i_ready),
        .o_vector      (o_vector),
        .o_div_by_zero (o_div_by_zero),
        .o_recip_sat   (o_recip_sat)
    );

    task automatic check_value(input string tag, input logic [127:0] actual,
                               input logic [127:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    // Drive one vertex, wait for the result, check it, optionally hold
    // i_ready low for 'hold' cycles, then complete the output handshake.
    task automatic run_vertex(input string name,
                              input logic [31:0] x, input logic [31:0] y,
                              input logic [31:0] z, input logic [31:0] w,
                              input logic [127:0] exp_vec,
                              input logic exp_dbz, input logic exp_sat,
                              input int exp_lat, input int hold);
        logic [127:0] held;
        int lat;
        @(negedge i_clk);
        check_value({name, " o_ready before accept"}, 128'(o_ready), 128'(1));
        i_vector = {x, y, z, w};
        i_valid  = 1'b1;
        i_ready  = (hold == 0);
        @(posedge i_clk);
        #1;
        i_valid  = 1'b0;
        // Operands are latched; scribbling on the input must not matter.
        i_vector = {$urandom, $urandom, $urandom, $urandom};
        lat = 1;
        while (!o_valid && lat < 100) begin
            @(posedge i_clk);
            #1;
            lat++;
        end
        check_value({name, " latency"}, 128'(lat), 128'(exp_lat));
        check_value({name, " o_vector"}, o_vector, exp_vec);
        check_value({name, " o_div_by_zero"}, 128'(o_div_by_zero), 128'(exp_dbz));
        check_value({name, " o_recip_sat"}, 128'(o_recip_sat), 128'(exp_sat));
        check_value({name, " o_ready while busy"}, 128'(o_ready), 128'(0));
        $display("vertex %s: in=%h_%h_%h_%h out=%h dbz=%0b sat=%0b latency=%0d",
                 name, x, y, z, w, o_vector, o_div_by_zero, o_recip_sat, lat);
        held = o_vector;
        for (int i = 0; i < hold; i++) begin
            @(posedge i_clk);
            #1;
            check_value({name, " o_valid held"}, 128'(o_valid), 128'(1));
            check_value({name, " o_vector held"}, o_vector, held);
            check_value({name, " o_ready held"}, 128'(o_ready), 128'(0));
        end
        i_ready = 1'b1;
        @(posedge i_clk);
        #1;
        check_value({name, " o_valid after handshake"}, 128'(o_valid), 128'(0));
        check_value({name, " o_ready after handshake"}, 128'(o_ready), 128'(1));
    endtask

    initial begin
        i_reset_n = 1'b0;
        i_valid   = 1'b0;
        i_ready   = 1'b1;
        i_vector  = '0;
        repeat (3) @(posedge i_clk);
        #1;
        check_value("reset o_ready", 128'(o_ready), 128'(1));
        check_value("reset o_valid", 128'(o_valid), 128'(0));
        check_value("reset o_vector", o_vector, 128'(0));
        check_value("reset o_div_by_zero", 128'(o_div_by_zero), 128'(0));
        check_value("reset o_recip_sat", 128'(o_recip_sat), 128'(0));
        i_reset_n = 1'b1;

        // 4/2, -2/2, 1/2, 1/2
        run_vertex("w2", 32'h0004_0000, 32'hFFFE_0000, 32'h0001_0000, 32'h0002_0000,
                   {32'h0002_0000, 32'hFFFF_0000, 32'h0000_8000, 32'h0000_8000},
                   1'b0, 1'b0, 35, 0);
        // w = -4.0, held off by backpressure, then back-to-back with the next
        run_vertex("wneg4", 32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'hFFFC_0000,
                   {32'hFFFF_C000, 32'hFFFF_C000, 32'hFFFF_C000, 32'hFFFF_C000},
                   1'b0, 1'b0, 35, 5);
        // w == 0 bypasses the divider
        run_vertex("wzero", 32'h0005_0000, 32'h0001_0000, 32'h0002_0000, 32'h0000_0000,
                   {32'h0, 32'h0, 32'h0, 32'h7FFF_FFFF},
                   1'b1, 1'b0, 1, 0);
        // w = 2^-16: 1/w saturates; y=1.0 -> MAX, z=-1.0 -> -MAX
        run_vertex("wtiny", 32'h0000_0000, 32'h0001_0000, 32'hFFFF_0000, 32'h0000_0001,
                   {32'h0, 32'h7FFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFF},
                   1'b0, 1'b1, 35, 0);
        // w = -2^-16: saturates, then negated
        run_vertex("wtinyneg", 32'h0001_0000, 32'h0, 32'h0, 32'hFFFF_FFFF,
                   {32'h8000_0001, 32'h0, 32'h0, 32'h8000_0001},
                   1'b0, 1'b1, 35, 0);
        // w = 3.0: 1/3 truncates to 0x5555
        run_vertex("w3", 32'h0003_0000, 32'hFFFF_0000, 32'h0, 32'h0003_0000,
                   {32'h0000_FFFF, 32'hFFFF_AAAB, 32'h0, 32'h0000_5555},
                   1'b0, 1'b0, 35, 0);
        // most negative w: |w| = 2^31, 1/w = -2 LSB
        run_vertex("wmin", 32'h0001_0000, 32'h7FFF_0000, 32'h0, 32'h8000_0000,
                   {32'hFFFF_FFFE, 32'hFFFF_0002, 32'h0, 32'hFFFF_FFFE},
                   1'b0, 1'b0, 35, 0);
        // w = 2^-8: x=256.0 overflows and wraps to 0
        run_vertex("wrap", 32'h0100_0000, 32'h0001_0000, 32'h0000_8000, 32'h0000_0100,
                   {32'h0, 32'h0100_0000, 32'h0080_0000, 32'h0100_0000},
                   1'b0, 1'b0, 35, 0);

        // Reset in the middle of a divide discards the vertex; a w==0 vertex
        // offered during the reset cycle must not be taken.
        @(negedge i_clk);
        i_vector = {32'h0004_0000, 32'hFFFE_0000, 32'h0001_0000, 32'h0002_0000};
        i_valid  = 1'b1;
        i_ready  = 1'b1;
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        repeat (9) @(posedge i_clk);
        @(negedge i_clk);
        i_reset_n = 1'b0;
        i_valid   = 1'b1;
        i_vector  = {32'h0005_0000, 32'h0, 32'h0, 32'h0};
        @(posedge i_clk);
        #1;
        check_value("midreset o_valid", 128'(o_valid), 128'(0));
        check_value("midreset o_ready", 128'(o_ready), 128'(1));
        check_value("midreset o_vector", o_vector, 128'(0));
        i_reset_n = 1'b1;
        i_valid   = 1'b0;
        @(posedge i_clk);
        #1;
        check_value("midreset ignored input", 128'(o_valid), 128'(0));
        check_value("midreset still ready", 128'(o_ready), 128'(1));

        run_vertex("after_reset", 32'h0004_0000, 32'hFFFE_0000, 32'h0001_0000, 32'h0002_0000,
                   {32'h0002_0000, 32'hFFFF_0000, 32'h0000_8000, 32'h0000_8000},
                   1'b0, 1'b0, 35, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/vertex_perspective_divide.md
Name: vertex_perspective_divide

Overview:
- Consumer-side stage that receives clip-space Vector4_t results from the matrix–vector transform and converts them back to normalised device coordinates.
- Computes x/w, y/w and z/w, and returns 1/w for perspective-correct interpolation.
- Uses one iterative reciprocal divider plus three fixed-point multiplies.
- Sits between the vertex transform and the rasteriser setup.
- Valid/ready handshake on both sides; one vertex is in flight at a time.

Parameters:
- WIDTH, default `FIXEDPOINT_WIDTH (32): signed fixed-point word width.
- FRAC, default `FIXEDPOINT_FRAC (16): number of fractional bits (Q16.16).

Ports:
- i_clk  in  1  clock; everything is on the rising edge.
- i_reset_n  in  1  synchronous, active-low reset.
- i_valid  in  1  input vector valid.
- o_ready  out  1  block can accept an input.
- i_vector  in  4*WIDTH  Vector4_t {x,y,z,w}, clip space.
- o_valid  out  1  result valid.
- i_ready  in  1  downstream accepts the result.
- o_vector  out  4*WIDTH  Vector4_t {x/w, y/w, z/w, 1/w}.
- o_div_by_zero  out  1  input w was exactly 0; qualified by o_valid.
- o_recip_sat  out  1  1/w saturated; qualified by o_valid.

Behaviour:
- Reset (i_reset_n==0 at an edge): state IDLE, o_ready=1, o_valid=0, o_vector=0, both flags 0.
  - Reset mid-operation discards the in-flight vertex.
  - i_valid is ignored during the reset cycle.
- States: IDLE, DIVIDE, SCALE, OUTPUT.
- o_ready=1 only in IDLE. An accept occurs when i_valid && o_ready at cycle T.
  - The block latches i_vector.
  - It forms |w| and the sign of w.
- IDLE on accept:
  - If w==0, go to OUTPUT: o_vector={0,0,0,0x7FFF_FFFF}, o_div_by_zero=1. o_valid is visible at T+1.
  - Otherwise go to DIVIDE.
- DIVIDE: restoring division of 2^(2*FRAC) by |w|.
  - One quotient bit per cycle, WIDTH+1 cycles (T+1 .. T+WIDTH+1), giving an unsigned quotient of WIDTH+1 bits.
  - If the quotient exceeds 2^(WIDTH-1)-1, recip = 2^(WIDTH-1)-1 and o_recip_sat=1.
  - Otherwise recip = quotient.
  - Negate recip if w<0.
- SCALE (cycle T+WIDTH+2): each component is fixed-point multiplied by recip.
  - x' = (x*recip)>>>FRAC, computed at 2*WIDTH bits with an arithmetic shift; the low WIDTH bits are kept.
  - y' and z' are formed the same way. There is no saturation and overflow wraps.
  - w' = recip.
  - Results are registered into o_vector, and the state goes to OUTPUT.
- OUTPUT: o_valid=1, visible from T+WIDTH+3, which is T+35 for WIDTH=32.
  - o_vector and the flags hold stable while i_ready==0.
  - On the o_valid && i_ready cycle the state goes to IDLE and o_valid drops on the next edge.
  - o_ready is 1 one cycle after the output handshake. No accept can occur in the same cycle as the output handshake.
- Flags clear on each new accept.
- i_vector changes while busy are ignored, since the operands are latched.

Decomposition:
- Shared package gpu_math_pkg holds:
  - Vector4_t
  - FIXEDPOINT_WIDTH and FIXEDPOINT_FRAC
  - the fixed_point_multiply function
  - the FIXEDPOINT_MAX constant (0x7FFF_FFFF)
- Sub-module fixed_point_reciprocal:
  - Inputs: start, unsigned divisor.
  - Outputs: busy, done, quotient, sat.
  - Implements the WIDTH+1-cycle restoring divider.
  - The top level owns the FSM, the sign handling and the SCALE multiplies.

Test Plan:
- x=4.0, y=-2.0, z=1.0, w=2.0 (0x0004_0000, 0xFFFE_0000, 0x0001_0000, 0x0002_0000) with i_ready=1 → at T+35: o_vector = {0x0002_0000, 0xFFFF_0000, 0x0000_8000, 0x0000_8000}, both flags 0.
- x=y=z=1.0, w=-4.0 (0xFFFC_0000) → x'=y'=z'=0xFFFF_C000 (-0.25), w'=0xFFFF_C000.
- w=0, x=5.0 → o_valid at T+1, o_vector = {0, 0, 0, 0x7FFF_FFFF}, o_div_by_zero=1.
- w=0x0000_0001 (2^-16), x=0 → w'=0x7FFF_FFFF, o_recip_sat=1, x'=0, latency 35.
- Backpressure: hold i_ready=0 for 5 cycles after o_valid → o_vector is stable and o_ready stays 0. Then raise i_ready → o_valid=0 next cycle, o_ready=1, and back-to-back vertices are accepted.
- Reset pulse at T+10 of a divide → next cycle o_valid=0, o_ready=1. A fresh vertex then completes with correct values.
